// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX definitions: control-bundle layout, ALU op encodings and the bubble constant.
// The ctrl bundle is {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp}.
package id_ex_pipe_reg_pkg;

  localparam int ALUOP_W_DEF = 4;
  localparam int CTRL_FLAG_N = 6;
  localparam int CTRL_W      = CTRL_FLAG_N + ALUOP_W_DEF;

  localparam int CTRL_REGWRITE  = CTRL_W - 1;
  localparam int CTRL_MEMREAD   = CTRL_W - 2;
  localparam int CTRL_MEMWRITE  = CTRL_W - 3;
  localparam int CTRL_MEMTOREG  = CTRL_W - 4;
  localparam int CTRL_ALUSRC    = CTRL_W - 5;
  localparam int CTRL_REGDST    = CTRL_W - 6;
  localparam int CTRL_ALUOP_MSB = ALUOP_W_DEF - 1;
  localparam int CTRL_ALUOP_LSB = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALUOP_ADD = 4'd0,
    ALUOP_SUB = 4'd1,
    ALUOP_AND = 4'd2,
    ALUOP_OR  = 4'd3,
    ALUOP_SLT = 4'd4
  } alu_op_e;

  // MemRead position for an arbitrary ALUOp width (flags sit directly above ALUOp).
  function automatic int ctrl_memread_bit(input int aluop_w);
    return aluop_w + 4;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble/flush/hold control and the responder side of the
// load-use stall handshake; also counts inserted bubbles and applied flushes.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 2,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       InsertBubble,
  input  logic                       Flush,
  input  logic                       Hold,
  input  logic                       id_valid,
  input  logic [DATA_W-1:0]          id_pc,
  input  logic [DATA_W-1:0]          id_rs_data,
  input  logic [DATA_W-1:0]          id_rt_data,
  input  logic [DATA_W-1:0]          id_imm,
  input  logic [REG_W-1:0]           id_rs,
  input  logic [REG_W-1:0]           id_rt,
  input  logic [REG_W-1:0]           id_rd,
  input  logic [CTRL_FLAG_N+ALUOP_W-1:0] id_ctrl,
  output logic                       ex_valid,
  output logic [DATA_W-1:0]          ex_pc,
  output logic [DATA_W-1:0]          ex_rs_data,
  output logic [DATA_W-1:0]          ex_rt_data,
  output logic [DATA_W-1:0]          ex_imm,
  output logic [REG_W-1:0]           ex_rs,
  output logic [REG_W-1:0]           ex_rt,
  output logic [REG_W-1:0]           ex_rd,
  output logic [CTRL_FLAG_N+ALUOP_W-1:0] ex_ctrl,
  output logic                       ID_EX_MemRead,
  output logic [CNT_W-1:0]           bubble_count,
  output logic [CNT_W-1:0]           flush_count
);

  localparam int CW     = CTRL_FLAG_N + ALUOP_W;
  localparam int MR_BIT = ctrl_memread_bit(ALUOP_W);

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_W-1:0]  rs_q,      rs_d;
  logic [REG_W-1:0]  rt_q,      rt_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [CW-1:0]     ctrl_q,    ctrl_d;
  logic              bubble_inc;

  // Priority Flush > Hold > InsertBubble > load. A bubble is an all-zero slot, so it can never
  // read as MemRead: the hazard unit's InsertBubble is answered on the next edge and drops itself.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    if (Flush || (!Hold && InsertBubble)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      ctrl_d    = CW'(CTRL_BUBBLE);
    end else if (!Hold) begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      ctrl_d    = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Only a bubble that actually lands is counted (not under Flush or Hold).
  assign bubble_inc = InsertBubble && !Flush && !Hold;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bubble_inc),
    .count   (bubble_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (Flush),
    .count   (flush_count)
  );

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign ID_EX_MemRead = valid_q & ctrl_q[MR_BIT];

endmodule
